lc3_fetch_ctrl: RTL

Fetch-stage sequencer for the LC3 CPU. Owns the program counter and drives the `fetch_out` bus signals (`npc`, `pc`, `instrmem_rd`) toward instruction memory. It runs a request/acknowledge transfer with instruction memory and buffers one fetched instruction for decode behind a valid/ready handshake. Branch redirects from execute squash any in-flight or buffered instruction.

---
 rtl/lc3_fetch_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lc3_fetch_ctrl.sv
// rtl/lc3_fetch_ctrl.sv - LC3 fetch sequencer: PC, imem handshake, one-entry IR buffer (optional LC3_FETCH_CTRL_PERF_EN counters)
module lc3_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  input  logic        imem_ack,
  input  logic [15:0] imem_dout,
  input  logic        ir_ready,
  output logic [15:0] pc,
  output logic [15:0] npc,
  output logic        instrmem_rd,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  output logic [15:0] fetch_cnt,
  output logic [15:0] squash_cnt
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        rd_req;
  logic        capture;
  logic        squash;

  // State, PC and instruction buffer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      ir_pc_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
    end
  end

  // Next-state logic: capture, redirect and drain of the abandoned transfer
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    rd_req  = 1'b0;
    capture = 1'b0;
    squash  = 1'b0;
    case (state_q)
      FETCH: begin
        rd_req = 1'b1;
        if (imem_ack && !br_taken) begin
          capture = 1'b1;
          ir_d    = imem_dout;
          ir_pc_d = pc_q;
          pc_d    = npc;
          state_d = HOLD;
        end else if (imem_ack && br_taken) begin
          squash = 1'b1;
          pc_d   = taddr;
        end else if (br_taken) begin
          // The read already issued for the old pc must still complete.
          pc_d    = taddr;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        rd_req = 1'b1;
        if (br_taken) begin
          pc_d = taddr;
        end
        if (imem_ack) begin
          squash  = 1'b1;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (br_taken) begin
          squash  = 1'b1;
          pc_d    = taddr;
          state_d = FETCH;
        end else if (ir_ready) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign npc         = pc_q + 16'd1;
  assign pc          = pc_q;
  assign instrmem_rd = rd_req & ~reset;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = (state_q == HOLD);

`ifdef LC3_FETCH_CTRL_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] squash_cnt_q;

  // Saturating performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q  <= 16'h0000;
      squash_cnt_q <= 16'h0000;
    end else begin
      if (capture && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      if (squash && (squash_cnt_q != 16'hFFFF)) begin
        squash_cnt_q <= squash_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = capture | squash;
  assign fetch_cnt   = 16'h0000;
  assign squash_cnt  = 16'h0000;
`endif

endmodule
